// File: rtl/conv_norm_issuer.sv
// Client end of the fixed-latency pipelined divider: forms operands, tracks in-flight
// ops with a tag pipe, saturates quotients to pixels and buffers them in a credited FWFT FIFO.
module conv_norm_issuer #(
  parameter int unsigned DIV_LATENCY = 5,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned FIFO_AW     = 3
) (
  input  logic        clock,
  input  logic        aclr_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_sum,
  input  logic [14:0] in_wsum,
  output logic [22:0] div_numer,
  output logic [14:0] div_denom,
  input  logic [10:0] div_quotient,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_pixel,
  output logic        out_zdiv
);

  localparam int unsigned TL = DIV_LATENCY;
  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW:0] CNT_ONE = (FIFO_AW+1)'(1);

  logic        accept;
  logic        pop;
  logic        w_zero;
  logic        neg_c;
  logic        sat_c;
  logic [14:0] den_c;

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  always_comb begin
    w_zero = (in_wsum == '0);
    den_c  = w_zero ? 15'd1 : in_wsum;
    neg_c  = in_sum[23];
    // 24-bit compare flags every quotient > 255, even those the 11-bit quotient truncates
    sat_c  = !neg_c && ({1'b0, in_sum[22:0]} >= {1'b0, den_c, 8'h00});
  end

  // Idle cycles present 0/1 so the divider never sees a zero denominator
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      div_numer <= '0;
      div_denom <= 15'd1;
    end else if (accept) begin
      div_numer <= neg_c ? '0 : in_sum[22:0];
      div_denom <= den_c;
    end else begin
      div_numer <= '0;
      div_denom <= 15'd1;
    end
  end

  logic [TL:0] tag_v;
  logic [TL:0] tag_neg;
  logic [TL:0] tag_sat;
  logic [TL:0] tag_zd;

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      tag_v   <= '0;
      tag_neg <= '0;
      tag_sat <= '0;
      tag_zd  <= '0;
    end else begin
      tag_v   <= {tag_v[TL-1:0],   accept};
      tag_neg <= {tag_neg[TL-1:0], accept && neg_c};
      tag_sat <= {tag_sat[TL-1:0], accept && sat_c};
      tag_zd  <= {tag_zd[TL-1:0],  accept && w_zero};
    end
  end

  logic       res_push;
  logic [7:0] res_pixel;
  logic       res_zd;
  logic       unused_quot_hi;

  always_comb begin
    res_push  = tag_v[TL];
    res_zd    = tag_zd[TL];
    res_pixel = div_quotient[7:0];
    if (tag_neg[TL]) begin
      res_pixel = '0;
    end else if (tag_sat[TL]) begin
      res_pixel = '1;
    end
  end

  assign unused_quot_hi = ^div_quotient[10:8];

  logic [7:0]         mem_pixel [FIFO_DEPTH];
  logic               mem_zd    [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW-1:0] rd_next;
  logic [FIFO_AW:0]   fifo_count;
  logic [FIFO_AW:0]   fifo_count_next;

  assign rd_next   = rd_ptr + 1'b1;
  assign out_valid = (fifo_count != '0);

  always_comb begin
    fifo_count_next = fifo_count;
    case ({res_push, pop})
      2'b10:   fifo_count_next = fifo_count + 1'b1;
      2'b01:   fifo_count_next = fifo_count - 1'b1;
      default: fifo_count_next = fifo_count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (res_push) begin
      mem_pixel[wr_ptr] <= res_pixel;
      mem_zd[wr_ptr]    <= res_zd;
    end
  end

  // Head is kept in out_pixel/out_zdiv so they hold their last value once empty
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      out_pixel  <= '0;
      out_zdiv   <= 1'b0;
    end else begin
      fifo_count <= fifo_count_next;
      if (res_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_next;
      end
      if (res_push && ((fifo_count == '0) || ((fifo_count == CNT_ONE) && pop))) begin
        out_pixel <= res_pixel;
        out_zdiv  <= res_zd;
      end else if (pop && (fifo_count > CNT_ONE)) begin
        out_pixel <= mem_pixel[rd_next];
        out_zdiv  <= mem_zd[rd_next];
      end
    end
  end

  logic [FIFO_AW:0] occ;
  logic [FIFO_AW:0] occ_next;

  always_comb begin
    occ_next = occ;
    case ({accept, pop})
      2'b10:   occ_next = occ + 1'b1;
      2'b01:   occ_next = occ - 1'b1;
      default: occ_next = occ;
    endcase
  end

  // Credits cover in-flight tags plus FIFO entries, so a granted op always has a slot
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      occ      <= '0;
      in_ready <= 1'b0;
    end else begin
      occ      <= occ_next;
      in_ready <= (occ_next < DEPTH_C);
    end
  end

endmodule
